ibex_div_iter: RTL
==================

# ibex_div_iter

Iterative 32-bit radix-2 restoring divider executing the RV32M DIV/DIVU/REM/REMU operations encoded by `md_op_e` (`MD_OP_DIV`, `MD_OP_REM`) from `ibex_pkg`. It sits in the EX stage beside the ALU, takes operands from the ID stage with a valid/ready handshake, and returns one 32-bit result to the writeback mux. Divide-by-zero and signed overflow complete on an early-out path.

## Interface
- `DataW`, 32: operand/result width; only 32 is supported.
- `clk_i`  in  1  clock.
- `rst_i`  in  1  reset; synchronous, active-high.
- `valid_i`  in  1  request valid.
- `ready_o`  out  1  divider can accept a request; high only in IDLE.
- `op_i`  in  `md_op_e`  `MD_OP_DIV` or `MD_OP_REM`; `MD_OP_MULL`/`MD_OP_MULH` requests are ignored (no state change).
- `signed_i`  in  1  1 = DIV/REM, 0 = DIVU/REMU.
- `op_a_i`  in  32  dividend.
- `op_b_i`  in  32  divisor.
- `kill_i`  in  1  abort the current operation (flush/exception).
- `valid_o`  out  1  result valid; high only in DONE.
- `ready_i`  in  1  consumer accepts the result.
- `result_o`  out  32  quotient for DIV, remainder for REM; 0 when `valid_o` is low.

## Operation
- FSM states: IDLE, CALC, FIX, DONE.
- Accept: `valid_i & ready_o` with op DIV/REM. The block latches the op, the signed flag, and the operand signs. It stores |a| and |b| when signed, and the raw values otherwise.
- Early-out from IDLE goes directly to DONE:
  - b == 0: quotient 0xFFFFFFFF, remainder = a (unmodified).
  - Signed with a == 0x80000000 and b == 0xFFFFFFFF: quotient 0x80000000, remainder 0.
- CALC: 32 iterations driven by a 5-bit counter that loads 31 and counts down to 0.
  - Each step: partial = {rem[31:0], quot[31]} − divisor, computed at 33 bits.
  - If non-negative, rem takes partial and quotient bit 1 is shifted in; otherwise rem is kept (with shifted-in bit) and 0 is shifted in.
  - The iteration with counter 0 moves the FSM to FIX.
- FIX: when signed, quotient is negated if sign(a) ≠ sign(b), and remainder is negated if a was negative. The selected value is written to the result register, then the FSM moves to DONE.
- DONE: `valid_o` = 1 and `result_o` is held stable until `ready_i`. On `ready_i` the FSM returns to IDLE and the next request cannot be accepted before the following cycle.
- `kill_i` in any state forces IDLE on the next edge and discards the result, with no `valid_o` pulse. `kill_i` has priority over `ready_i` and `valid_i`.
- Reset: FSM goes to IDLE, counter and all datapath registers to 0, `valid_o` = 0, `ready_o` = 1 (from the first cycle after reset deassertion), `result_o` = 0.
- Reset asserted during CALC/FIX/DONE: identical to kill; no partial result escapes.

## Timing
- Request accepted at the edge ending cycle 0:
  - Normal path: CALC occupies cycles 1–32, FIX cycle 33, and `valid_o` rises in cycle 34.
  - Early-out: `valid_o` rises in cycle 1.
- Throughput: one operation per 35 cycles minimum (DONE → IDLE → accept).
- All outputs come from registers or FSM state decode only; there is no combinational path from inputs to outputs except `result_o`/`valid_o` gating by state.
- Operand inputs are sampled only at the accept edge; later changes are ignored.

## Structure
- `ibex_pkg` additions:
  - `div_fsm_e` (logic [1:0]: `DIV_IDLE`, `DIV_CALC`, `DIV_FIX`, `DIV_DONE`).
  - Parameter `DIV_ITERATIONS` = 32.
- Reuses `md_op_e` from `ibex_pkg`; no new op enum.
- One natural sub-module: `ibex_div_step`, a combinational single restoring step. It takes rem, quot MSB and divisor, and returns the next rem and the quotient bit.

## Test plan
- Unsigned 100 ÷ 7, DIV and REM: results 14 and 2; `valid_o` in cycle 34; `ready_o` low in cycles 1–34.
- Signed −7 ÷ 2: DIV = 0xFFFFFFFD and REM = 0xFFFFFFFF. Signed 7 ÷ −2: DIV = 0xFFFFFFFD and REM = 1.
- Divide-by-zero, 5 ÷ 0 (signed and unsigned): DIV = 0xFFFFFFFF and REM = 5, with `valid_o` in cycle 1.
- Overflow, 0x80000000 ÷ 0xFFFFFFFF signed: DIV = 0x80000000 and REM = 0, in cycle 1. The same operands unsigned give DIV = 0 and REM = 0x80000000 after the full 34 cycles.
- Kill/reset: `kill_i` in cycle 10 gives IDLE in cycle 11, `ready_o` = 1, and `valid_o` never rises. The same test repeated with `rst_i` gives the same result. A new request immediately after kill completes correctly.
- Backpressure: `ready_i` held low for 5 cycles in DONE keeps `valid_o`/`result_o` stable and `ready_o` low. A `MD_OP_MULL` request in IDLE is ignored, with the FSM staying in IDLE.

Source files
------------

// File: rtl/ibex_pkg.sv
// Shared ibex types: multiply/divide op encoding plus iterative divider FSM states.
package ibex_pkg;

    typedef enum logic [1:0] {
        MD_OP_MULL = 2'b00,
        MD_OP_MULH = 2'b01,
        MD_OP_DIV  = 2'b10,
        MD_OP_REM  = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'b00,
        DIV_CALC = 2'b01,
        DIV_FIX  = 2'b10,
        DIV_DONE = 2'b11
    } div_fsm_e;

    parameter int unsigned DIV_ITERATIONS = 32;
    localparam int unsigned DIV_CNT_W     = $clog2(DIV_ITERATIONS);

endpackage

// File: rtl/ibex_div_step.sv
// One restoring-division step: trial-subtract the divisor from the shifted partial remainder.
module ibex_div_step #(
    parameter int unsigned DataW = 32
) (
    input  logic [DataW-1:0] rem_i,
    input  logic             quot_msb_i,
    input  logic [DataW-1:0] divisor_i,
    output logic [DataW-1:0] rem_c,
    output logic             quot_bit_c
);

    logic [DataW:0] partial;

    always_comb begin
        partial    = {rem_i, quot_msb_i} - {1'b0, divisor_i};
        quot_bit_c = ~partial[DataW];
        // On a failed trial the shifted value is still below the divisor, so its top bit is zero.
        rem_c      = quot_bit_c ? partial[DataW-1:0] : {rem_i[DataW-2:0], quot_msb_i};
    end

endmodule

// File: rtl/ibex_div_iter.sv
// Iterative 32-bit restoring divider for DIV/DIVU/REM/REMU with early-out for
// divide-by-zero and signed overflow.
module ibex_div_iter
    import ibex_pkg::*;
#(
    parameter int unsigned DataW = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  md_op_e           op_i,
    input  logic             signed_i,
    input  logic [DataW-1:0] op_a_i,
    input  logic [DataW-1:0] op_b_i,
    input  logic             kill_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [DataW-1:0] result_o
);

    localparam int unsigned CntW = DIV_CNT_W;
    localparam logic [DataW-1:0] MinNeg = {1'b1, {(DataW-1){1'b0}}};

    div_fsm_e         state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [DataW-1:0] rem_q, rem_d;
    logic [DataW-1:0] quot_q, quot_d;
    logic [DataW-1:0] div_q, div_d;
    logic [DataW-1:0] result_q, result_d;
    md_op_e           op_q, op_d;
    logic             signed_q, signed_d;
    logic             a_neg_q, a_neg_d;
    logic             b_neg_q, b_neg_d;

    logic [DataW-1:0] step_rem;
    logic             step_bit;
    logic             accept;
    logic             a_neg, b_neg;
    logic [DataW-1:0] a_abs, b_abs;
    logic [DataW-1:0] quot_fix, rem_fix;

    ibex_div_step #(
        .DataW (DataW)
    ) u_step (
        .rem_i      (rem_q),
        .quot_msb_i (quot_q[DataW-1]),
        .divisor_i  (div_q),
        .rem_c      (step_rem),
        .quot_bit_c (step_bit)
    );

    // Next-state and datapath update
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        quot_d   = quot_q;
        div_d    = div_q;
        result_d = result_q;
        op_d     = op_q;
        signed_d = signed_q;
        a_neg_d  = a_neg_q;
        b_neg_d  = b_neg_q;

        accept   = valid_i & ~kill_i & ((op_i == MD_OP_DIV) | (op_i == MD_OP_REM));
        a_neg    = signed_i & op_a_i[DataW-1];
        b_neg    = signed_i & op_b_i[DataW-1];
        a_abs    = a_neg ? -op_a_i : op_a_i;
        b_abs    = b_neg ? -op_b_i : op_b_i;
        quot_fix = (signed_q & (a_neg_q ^ b_neg_q)) ? -quot_q : quot_q;
        rem_fix  = (signed_q & a_neg_q) ? -rem_q : rem_q;

        case (state_q)
            DIV_IDLE: begin
                if (accept) begin
                    op_d     = op_i;
                    signed_d = signed_i;
                    a_neg_d  = a_neg;
                    b_neg_d  = b_neg;
                    if (op_b_i == '0) begin
                        result_d = (op_i == MD_OP_REM) ? op_a_i : '1;
                        state_d  = DIV_DONE;
                    end else if (signed_i && (op_a_i == MinNeg) && (op_b_i == '1)) begin
                        result_d = (op_i == MD_OP_REM) ? '0 : MinNeg;
                        state_d  = DIV_DONE;
                    end else begin
                        rem_d   = '0;
                        quot_d  = a_abs;
                        div_d   = b_abs;
                        cnt_d   = CntW'(DIV_ITERATIONS - 1);
                        state_d = DIV_CALC;
                    end
                end
            end
            DIV_CALC: begin
                rem_d  = step_rem;
                quot_d = {quot_q[DataW-2:0], step_bit};
                cnt_d  = cnt_q - CntW'(1);
                if (cnt_q == '0) begin
                    state_d = DIV_FIX;
                end
            end
            DIV_FIX: begin
                result_d = (op_q == MD_OP_REM) ? rem_fix : quot_fix;
                state_d  = DIV_DONE;
            end
            DIV_DONE: begin
                if (ready_i) begin
                    state_d = DIV_IDLE;
                end
            end
            default: state_d = DIV_IDLE;
        endcase

        // Flush wins over everything; any in-flight result is simply never presented.
        if (kill_i) begin
            state_d = DIV_IDLE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= DIV_IDLE;
            cnt_q    <= '0;
            rem_q    <= '0;
            quot_q   <= '0;
            div_q    <= '0;
            result_q <= '0;
            op_q     <= MD_OP_MULL;
            signed_q <= 1'b0;
            a_neg_q  <= 1'b0;
            b_neg_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            quot_q   <= quot_d;
            div_q    <= div_d;
            result_q <= result_d;
            op_q     <= op_d;
            signed_q <= signed_d;
            a_neg_q  <= a_neg_d;
            b_neg_q  <= b_neg_d;
        end
    end

    assign ready_o  = (state_q == DIV_IDLE);
    assign valid_o  = (state_q == DIV_DONE);
    assign result_o = valid_o ? result_q : '0;

endmodule
